mult_seq_unit: RTL and testbench

- Parametrised sequential multiplier built from a shared-bus datapath (registers A, B, P plus an adder) and a control FSM.
- Operands arrive on one input bus in two consecutive cycles: A first, then B.
- Two runtime modes: repeated addition (P += A, B decremented) and shift-add with early termination.
- Sits between bus-driving logic and consumers of a 2*WIDTH product; adds a start/busy/done handshake.

---
 rtl/mult_seq_unit_pkg.sv | 15 +
 rtl/mult_seq_unit_if.sv | 23 ++
 rtl/mult_seq_unit_b_reg.sv | 33 +++
 rtl/mult_seq_unit.sv | 124 ++++++++++++
 tb/tb_mult_seq_unit.sv | 136 +++++++++++++
 5 files changed

// File: rtl/mult_seq_unit_pkg.sv
// Shared types and constants for the sequential multiplier: FSM state encoding
// and the runtime mode selector values.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    ACC    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic MODE_REPADD = 1'b0;
  localparam logic MODE_SHIFT  = 1'b1;

endpackage

// File: rtl/mult_seq_unit_if.sv
// Operand bus and start/busy/done handshake of the sequential multiplier.
// The master drives operands and requests; the slave returns status and product.
interface mult_seq_unit_if #(
  parameter int WIDTH = 15
);
  logic [WIDTH-1:0]   data_in;
  logic               start;
  logic               mode;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               eqz;

  modport master (
    output data_in, start, mode,
    input  busy, done, product, eqz
  );

  modport slave (
    input  data_in, start, mode,
    output busy, done, product, eqz
  );
endinterface

// File: rtl/mult_seq_unit_b_reg.sv
// Multiplier B operand register: parallel load, decrement (repeated add) or
// shift right (shift-add); flags a zero value combinationally.
module mult_b_reg #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic             i_shr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_b,
  output logic             o_eqz
);

  logic [WIDTH-1:0] r_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b <= '0;
    end else if (i_load) begin
      r_b <= i_d;
    end else if (i_dec) begin
      r_b <= r_b - 1'b1;
    end else if (i_shr) begin
      r_b <= r_b >> 1;
    end
  end

  assign o_b   = r_b;
  assign o_eqz = (r_b == '0);

endmodule

// File: rtl/mult_seq_unit.sv
// Sequential unsigned multiplier: A then B on a shared bus, product by repeated
// addition or by shift-add with early exit once the remaining multiplier is zero.
module mult_seq_unit
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 15,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  mult_seq_unit_if.slave bus
);

  state_t             r_state;
  state_t             w_next;
  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_p;
  logic [2*WIDTH-1:0] w_sum;
  logic               r_mode;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_b;
  logic               w_eqz;
  logic               w_load_a;
  logic               w_clr_p;
  logic               w_add_p;
  logic               w_shl_a;
  logic               w_b_load;
  logic               w_b_dec;
  logic               w_b_shr;

  localparam logic [WIDTH-1:0] B_ONE = WIDTH'(1);

  mult_b_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_b_load),
    .i_dec  (w_b_dec),
    .i_shr  (w_b_shr),
    .i_d    (bus.data_in),
    .o_b    (w_b),
    .o_eqz  (w_eqz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = LOAD_B;
      LOAD_B:  w_next = (bus.data_in == '0) ? DONE : ACC;
      ACC: begin
        // Shift-add stops once no set bits remain above the one consumed now
        if (r_mode == MODE_REPADD) begin
          if (w_b == B_ONE) w_next = DONE;
        end else begin
          if (w_b[WIDTH-1:1] == '0) w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load_a = 1'b0;
    w_clr_p  = 1'b0;
    w_add_p  = 1'b0;
    w_shl_a  = 1'b0;
    w_b_load = 1'b0;
    w_b_dec  = 1'b0;
    w_b_shr  = 1'b0;
    bus.busy = (r_state != IDLE);
    bus.done = 1'b0;
    case (r_state)
      IDLE:   w_load_a = bus.start;
      LOAD_B: begin
        w_b_load = 1'b1;
        w_clr_p  = 1'b1;
      end
      ACC: begin
        if (r_mode == MODE_REPADD) begin
          w_add_p = 1'b1;
          w_b_dec = 1'b1;
        end else begin
          w_add_p = w_b[0];
          w_shl_a = 1'b1;
          w_b_shr = 1'b1;
        end
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign w_sum = r_p + r_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_p    <= '0;
      r_mode <= MODE_REPADD;
      r_cnt  <= '0;
    end else begin
      if (w_load_a)     r_a <= {{WIDTH{1'b0}}, bus.data_in};
      else if (w_shl_a) r_a <= r_a << 1;
      if (w_clr_p)      r_p <= '0;
      else if (w_add_p) r_p <= w_sum;
      if (w_load_a)     r_mode <= bus.mode;
      if (w_clr_p)      r_cnt <= '0;
      else if (w_shl_a) r_cnt <= r_cnt + 1'b1;
    end
  end

  // A shift-add run never needs more steps than the operand has bits
  assert property (@(posedge clk) disable iff (rst)
    (r_state == ACC) |-> (r_cnt < CNT_W'(WIDTH)));

  assign bus.product = r_p;
  assign bus.eqz     = w_eqz;

endmodule

// File: tb/tb_mult_seq_unit.sv
// Self-checking bench for mult_seq_unit: directed cases plus random operations
// compared against a plain-arithmetic reference for product and latency.
module tb_mult_seq_unit;

  localparam int WIDTH = 15;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mult_seq_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_seq_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle of the done pulse, counting the start-accept cycle as cycle 0
  function automatic int ref_lat(input bit m, input int b);
    int k;
    if (b == 0) return 2;
    if (m == 1'b0) return 2 + b;
    k = 0;
    while (b != 0) begin
      k++;
      b = b >> 1;
    end
    return 2 + k;
  endfunction

  // Called at the start of an IDLE cycle (just after a rising edge)
  task automatic run_op(input string tag, input bit m, input int a, input int b, input bit hold);
    int              cyc;
    bit              seen;
    longint unsigned exp_p;
    exp_p = longint'(a) * longint'(b);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.data_in = a[WIDTH-1:0];
    @(posedge clk); #1;
    cyc = 1;
    check({tag, ".busy_load"}, 64'(bus.busy), 64'd1);
    bus.data_in = b[WIDTH-1:0];
    bus.start   = hold;
    bus.mode    = ~m;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      bus.data_in = WIDTH'($urandom);
      if (bus.done) seen = 1'b1;
    end
    check({tag, ".done_cyc"}, 64'(seen ? cyc : 9999), 64'(ref_lat(m, b)));
    check({tag, ".product"}, 64'(bus.product), exp_p);
    check({tag, ".eqz"}, 64'(bus.eqz), 64'd1);
    @(posedge clk); #1;
    check({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
    check({tag, ".done_after"}, 64'(bus.done), 64'd0);
    check({tag, ".product_hold"}, 64'(bus.product), exp_p);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.data_in = '0;
    rst = 1'b1;
    #12;
    check("reset.busy", 64'(bus.busy), 64'd0);
    check("reset.done", 64'(bus.done), 64'd0);
    check("reset.product", 64'(bus.product), 64'd0);
    check("reset.eqz", 64'(bus.eqz), 64'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Reset abandons an operation in flight
    bus.start = 1'b1; bus.mode = 1'b0; bus.data_in = WIDTH'(5);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.data_in = WIDTH'(7);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_mid.no_done_pre", 64'(bus.done), 64'd0);
    end
    check("rst_mid.partial_p", 64'(bus.product), 64'd10);
    rst = 1'b1;
    #1;
    check("rst_mid.busy", 64'(bus.busy), 64'd0);
    check("rst_mid.product", 64'(bus.product), 64'd0);
    check("rst_mid.eqz", 64'(bus.eqz), 64'd1);
    #2 rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("rst_mid.no_done", 64'(bus.done), 64'd0);
    end
    run_op("rst_op2", 1'b0, 3, 4, 1'b0);

    run_op("repadd", 1'b0, 5, 3, 1'b0);
    run_op("shift_max", 1'b1, 32767, 32767, 1'b0);
    run_op("shift_early", 1'b1, 9, 4, 1'b0);
    run_op("zero_b_m0", 1'b0, 1234, 0, 1'b0);
    run_op("zero_b_m1", 1'b1, 77, 0, 1'b0);
    run_op("zero_a_m1", 1'b1, 0, 6, 1'b0);
    run_op("zero_a_m0", 1'b0, 0, 9, 1'b0);

    // start held high: ignored while busy and in DONE, accepted next IDLE
    run_op("hold", 1'b0, 2, 2, 1'b1);
    run_op("b2b", 1'b1, 7, 9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      bit m;
      int a;
      int b;
      m = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 32767));
      if (m) b = int'($urandom_range(0, 32767));
      else   b = int'($urandom_range(0, 200));
      run_op($sformatf("rand%0d", i), m, a, b, 1'($urandom_range(0, 1)));
      bus.start = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
